// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment BCD encoder: active-low segment
// codes in {dp,g,f,e,d,c,b,a} order, FSM encoding and BCD sizing.
package seg7_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_ENCODE = 2'd2
    } state_e;

    // Five digits cover the full 16-bit range (65535).
    localparam int unsigned BCD_DIGITS = 5;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

    // Double-dabble correction: a digit of 5 or more would exceed 9 after
    // doubling, so pre-add 3 to make it carry into the next nibble.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// One BCD digit to active-low segment code. Non-decimal inputs (10..15)
// produce a blank, which the top uses to blank leading zeros.
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] code_o
);

    // Table lookup; dp stays off (1) in every entry.
    always_comb begin
        code_o = SEG_BLANK;
        case (digit_i)
            4'd0:    code_o = SEG_0;
            4'd1:    code_o = SEG_1;
            4'd2:    code_o = SEG_2;
            4'd3:    code_o = SEG_3;
            4'd4:    code_o = SEG_4;
            4'd5:    code_o = SEG_5;
            4'd6:    code_o = SEG_6;
            4'd7:    code_o = SEG_7;
            4'd8:    code_o = SEG_8;
            4'd9:    code_o = SEG_9;
            default: code_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_encoder.sv
// Binary to 4-digit seven-segment encoder using a bit-serial double-dabble
// engine (one input bit per clock). Output codes are registered and only
// change in ENCODE, so the scan stage never sees partial results.
//
// Build option: define SEG7_LZ_BLANK_EN to blank leading zero digits
// (units digit always shown).
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready; a request captures value and starts conversion
// S_SHIFT  | add-3 then shift, IN_W cycles, requests ignored
// S_ENCODE | register four codes (or dashes on overflow), pulse done
module seg7_bcd_encoder
    import seg7_pkg::*;
#(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned MAX_DISP = 9999
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] value,
    output logic            busy,
    output logic            done,
    output logic [7:0]      hb_up_code,
    output logic [7:0]      hb_dn_code,
    output logic [7:0]      lb_up_code,
    output logic [7:0]      lb_dn_code
);

    localparam int unsigned CNT_W = 5;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    shreg_q, shreg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         hb_up_q, hb_up_d, hb_dn_q, hb_dn_d;
    logic [7:0]         lb_up_q, lb_up_d, lb_dn_q, lb_dn_d;
    logic               done_q, done_d;

    logic [3:0]  d4, d3, d2, d1, d0;
    logic [3:0]  e3, e2, e1;
    logic [7:0]  c3, c2, c1, c0;
    logic [31:0] dec4;
    logic        ovf;
    logic        blank3, blank2, blank1;

    assign d0 = bcd_q[3:0];
    assign d1 = bcd_q[7:4];
    assign d2 = bcd_q[11:8];
    assign d3 = bcd_q[15:12];
    assign d4 = bcd_q[19:16];

    // Overflow check against MAX_DISP in decimal; the ten-thousands digit
    // alone already means the value cannot fit on four digits.
    assign dec4 = 32'(d3) * 32'd1000 + 32'(d2) * 32'd100 + 32'(d1) * 32'd10 + 32'(d0);
    assign ovf  = (d4 != 4'd0) || (dec4 > MAX_DISP);

`ifdef SEG7_LZ_BLANK_EN
    assign blank3 = (d3 == 4'd0);
    assign blank2 = blank3 && (d2 == 4'd0);
    assign blank1 = blank2 && (d1 == 4'd0);
`else
    assign blank3 = 1'b0;
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    // A blanked digit is fed to the encoder as 4'hF, which it maps to FF.
    assign e3 = blank3 ? 4'hF : d3;
    assign e2 = blank2 ? 4'hF : d2;
    assign e1 = blank1 ? 4'hF : d1;

    seg7_digit_enc u_enc3 (.digit_i(e3), .code_o(c3));
    seg7_digit_enc u_enc2 (.digit_i(e2), .code_o(c2));
    seg7_digit_enc u_enc1 (.digit_i(e1), .code_o(c1));
    seg7_digit_enc u_enc0 (.digit_i(d0), .code_o(c0));

    // Per-nibble add-3 correction ahead of each shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hb_up_d = hb_up_q;
        hb_dn_d = hb_dn_q;
        lb_up_d = lb_up_q;
        lb_dn_d = lb_dn_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d = value;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(IN_W);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // MSB of the corrected accumulator falls off; it is never set
                // because five digits hold any 16-bit value.
                {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ENCODE;
                end
            end
            S_ENCODE: begin
                if (ovf) begin
                    hb_up_d = SEG_DASH;
                    hb_dn_d = SEG_DASH;
                    lb_up_d = SEG_DASH;
                    lb_dn_d = SEG_DASH;
                end else begin
                    hb_up_d = c3;
                    hb_dn_d = c2;
                    lb_up_d = c1;
                    lb_dn_d = c0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset blanks the display and aborts
    // any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hb_up_q <= SEG_BLANK;
            hb_dn_q <= SEG_BLANK;
            lb_up_q <= SEG_BLANK;
            lb_dn_q <= SEG_BLANK;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hb_up_q <= hb_up_d;
            hb_dn_q <= hb_dn_d;
            lb_up_q <= lb_up_d;
            lb_dn_q <= lb_dn_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign hb_up_code = hb_up_q;
    assign hb_dn_code = hb_dn_q;
    assign lb_up_code = lb_up_q;
    assign lb_dn_code = lb_dn_q;

endmodule

// File: tb/tb_seg7_bcd_encoder.sv
// Directed bench for seg7_bcd_encoder (default IN_W=16, MAX_DISP=9999).
// Expected codes follow SEG7_LZ_BLANK_EN when it is defined.
module tb_seg7_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [7:0]  hb_up_code, hb_dn_code, lb_up_code, lb_dn_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_bcd_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .value      (value),
        .busy       (busy),
        .done       (done),
        .hb_up_code (hb_up_code),
        .hb_dn_code (hb_dn_code),
        .lb_up_code (lb_up_code),
        .lb_dn_code (lb_dn_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_codes(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
        chk({tag, "_hb_up"}, 32'(hb_up_code), 32'(e3));
        chk({tag, "_hb_dn"}, 32'(hb_dn_code), 32'(e2));
        chk({tag, "_lb_up"}, 32'(lb_up_code), 32'(e1));
        chk({tag, "_lb_dn"}, 32'(lb_dn_code), 32'(e0));
    endtask

    // Returns negedges after the accept edge until done is seen, or -1.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Issue one request at the next edge, then check latency, codes and
    // that done is a single-cycle pulse.
    task automatic convert(input logic [15:0] v, input string tag, input logic [7:0] e3,
                           input logic [7:0] e2, input logic [7:0] e1, input logic [7:0] e0);
        int lat;
        @(negedge clk);
        value    = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        wait_done(lat);
        chk({tag, "_latency"}, lat, 32'd17);
        chk_codes(tag, e3, e2, e1, e0);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        value    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state and idle stability.
        chk_codes("reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        value = 16'd1234;
        repeat (5) @(negedge clk);
        chk_codes("idle", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        chk("idle_done", 32'(done), 32'd0);

        convert(16'd1234, "v1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
        convert(16'd10000, "v10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        convert(16'd9999, "v9999", 8'h90, 8'h90, 8'h90, 8'h90);
        convert(16'd65535, "v65535", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
`ifdef SEG7_LZ_BLANK_EN
        convert(16'd7, "v7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
        convert(16'd0, "v0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
`else
        convert(16'd7, "v7", 8'hC0, 8'hC0, 8'hC0, 8'hF8);
        convert(16'd0, "v0", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

        // 42 with an ignored request and a value change mid-conversion.
        @(negedge clk);
        value    = 16'd42;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
`ifdef SEG7_LZ_BLANK_EN
        chk_codes("hold_mid_shift", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
`else
        chk_codes("hold_mid_shift", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif
        value    = 16'd555;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        value    = 16'd999;
        pulses   = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("v42_done_pulses", pulses, 32'd1);
`ifdef SEG7_LZ_BLANK_EN
        chk_codes("v42", 8'hFF, 8'hFF, 8'h99, 8'hA4);
`else
        chk_codes("v42", 8'hC0, 8'hC0, 8'h99, 8'hA4);
`endif

        // Back-to-back: second request issued in the done cycle.
        @(negedge clk);
        value    = 16'd1234;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        chk("b2b_first_latency", lat, 32'd17);
        chk_codes("b2b_first", 8'hF9, 8'hA4, 8'hB0, 8'h99);
        value    = 16'd3806;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_accepted_busy", 32'(busy), 32'd1);
        wait_done(lat);
        chk("b2b_second_latency", lat, 32'd17);
        chk_codes("b2b_second", 8'hB0, 8'h80, 8'hC0, 8'h82);

        // Reset in the middle of a 5678 conversion.
        @(negedge clk);
        value    = 16'd5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_codes("abort", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 32'd0);
        chk_codes("abort_hold", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        convert(16'd5678, "v5678", 8'h92, 8'h82, 8'hF8, 8'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_bcd_encoder.md
Name: seg7_bcd_encoder

Overview:
- Upstream feeder of the 4-digit seven-segment scan stage.
- Takes an unsigned binary value, e.g. the MNIST classification result or a cycle/score counter.
- Converts it to decimal with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Registers four active-low segment codes (hb_up, hb_dn, lb_up, lb_dn) that the scan stage multiplexes onto the anodes.

Parameters:
- IN_W, 16, width of binary input; legal range 4..16; conversion takes IN_W shift cycles.
- MAX_DISP, 9999, largest value shown; values above it display "----".

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request to convert value.
- in_ready  output  1  high when the block can accept a request.
- value  input  IN_W  unsigned binary value to display.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when the new codes are valid.
- hb_up_code  output  8  thousands digit segment code.
- hb_dn_code  output  8  hundreds digit segment code.
- lb_up_code  output  8  tens digit segment code.
- lb_dn_code  output  8  units digit segment code.

Behaviour:
- Segment code format: {dp,g,f,e,d,c,b,a}, active-low, dp always 1.
- Code table:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - blank=FF, dash=BF
- Reset (rst_n=0, asynchronous):
  - state=IDLE; in_ready=1 after release; busy=0; done=0.
  - All four codes=FF; shift register and BCD accumulator cleared.
- FSM IDLE:
  - in_ready=1.
  - On in_valid=1 at a clock edge, capture value and clear the 20-bit BCD accumulator (5 digits).
  - Load iteration counter = IN_W; go to SHIFT.
- FSM SHIFT:
  - busy=1, in_ready=0.
  - Each cycle: every BCD nibble >=5 gets +3, then {bcd,shreg} shifts left by 1 and the counter decrements.
  - When the counter reaches 1 (last shift done this edge), go to ENCODE.
- FSM ENCODE (one cycle):
  - If the captured value > MAX_DISP, all four codes=BF.
  - Otherwise each code is the table entry for its BCD digit.
  - done=1 for exactly this one cycle after the registered update; go to IDLE.
- Latency: accept at edge k, codes updated at edge k+IN_W+1, done high in the following cycle. Default IN_W=16 gives 17 edges.
- Output codes hold their last value until the next ENCODE; there are no partial updates during SHIFT.
- in_valid while busy is ignored, not queued.
- value changes after acceptance have no effect.
- in_valid asserted in the same cycle done is high is accepted (state is IDLE at that edge).
- Reset mid-conversion aborts immediately: codes return to FF and no done pulse is generated.
- 5th BCD digit (ten-thousands) is used only in the overflow compare; the arithmetic never wraps because 5 digits cover 2^16-1=65535.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading zero digits are blanked (FF), scanning from the thousands digit down. Units digit is always shown, so value 0 gives FF,FF,FF,C0. Overflow dashes are unaffected.
- Undefined: all four digits always shown, so 7 gives C0,C0,C0,F8.

Decomposition:
- Package seg7_pkg:
  - localparams SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - FSM state encoding S_IDLE/S_SHIFT/S_ENCODE (2 bits).
  - BCD digit count constant (5).
- Sub-module seg7_digit_enc: combinational 4-bit BCD to 8-bit code per the table; codes 10..15 map to FF. Instantiated four times in ENCODE.

Test Plan:
- Reset then idle -> all codes FF, in_ready=1, busy=0, done=0; no change while in_valid=0.
- value=1234, in_valid one cycle -> after 17 edges codes hb_up=F9, hb_dn=A4, lb_up=B0, lb_dn=99; done pulses exactly once.
- value=10000 and 65535 -> all codes BF; value=9999 -> all codes 90.
- value=7 with macro off -> C0,C0,C0,F8; with SEG7_LZ_BLANK_EN -> FF,FF,FF,F8. value=0 with macro -> FF,FF,FF,C0.
- Convert 42; during SHIFT pulse in_valid with 555 and change value -> result shows 42, one done; back-to-back request issued on the done cycle converts normally.
- Assert rst_n=0 mid-SHIFT on a 5678 conversion -> codes FF at once, no done; next request 5678 -> 92,82,F8,80.
